i2c_bit_engine: RTL
===================

// Module: i2c_bit_engine
// PURPOSE
//  Bus-level I2C master PHY directly downstream of the master driver. Consumes the
//  driver's start/send/receive byte commands; generates START, repeated START, STOP,
//  8-bit TX with ACK sampling, and 8-bit RX with ACK/NACK drive. Open-drain SCL/SDA
//  at a fixed rate. Returns sended/received pulses, datareceive and isReady.
// PARAMETERS
//  CLK_DIV   125  clk cycles per quarter SCL period (100 kHz @ 50 MHz); legal >= 2
// PORTS
//  clk          in   1  system clock; sole clock
//  reset        in   1  synchronous, active-high reset
//  isReady      out  1  1 = idle or holding bus between bytes; command accepted now
//  start        in   1  1-cycle command: START (or repeated START if bus held)
//  send         in   1  1-cycle command: transmit datasend, then sample ACK
//  datasend     in   8  TX byte, sampled in the cycle send is accepted; MSB first
//  sended       out  1  1-cycle pulse: TX byte + ACK slot complete
//  receive      in   1  1-cycle command: receive a byte, then drive ACK slot
//  nackLast     in   1  sampled with receive; 1 = drive NACK (last byte)
//  datareceive  out  8  RX byte; valid from the received pulse until next receive
//  received     out  1  1-cycle pulse: RX byte + ACK slot complete
//  stop         in   1  1-cycle command: STOP; bus released afterwards
//  ackError     out  1  SDA high in the last TX ACK slot; held until the next send
//  scl_oe       out  1  1 = pull SCL low; 0 = release
//  sda_oe       out  1  1 = pull SDA low; 0 = release
//  sda_i        in   1  synchronised SDA pin level
//  scl_i        in   1  synchronised SCL pin level; used only with stretching
// BEHAVIOUR
//  Reset values: isReady=1, sended=0, received=0, datareceive=0, ackError=0,
//   scl_oe=0, sda_oe=0; FSM=IDLE; timer=0.
//  Reset mid-transfer: lines are released on the next edge; slave recovery is the
//   driver's responsibility.
//  Quarter timer counts 0..CLK_DIV-1 and emits tick at CLK_DIV-1. Width is
//   $clog2(CLK_DIV). One bit slot is 4 ticks: q0 SCL low/set SDA, q1 SCL release,
//   q2 SCL high/sample SDA (at the q2 tick), q3 SCL low.
//  Timer runs only outside IDLE and HOLD. It restarts at 0 when a command is accepted.
//  FSM states: IDLE, START, BITS, ACK, HOLD, STOP.
//   IDLE  bus released. start -> START. send, receive and stop are ignored.
//   START 4 ticks. q0 SDA released, q1 SCL released, q2 SDA low (SCL high),
//         q3 SCL low -> HOLD. From HOLD, the same sequence is a repeated START.
//   BITS  8 slots; bit counter 7..0. TX: sda_oe = ~bit. RX: SDA released, bit
//         shifted in at the q2 tick. After slot 0 -> ACK.
//   ACK   1 slot. TX: SDA released; ackError <= sda_i at the q2 tick.
//         RX: sda_oe = ~nackLast.
//         At the q3 tick: sended or received pulses on the next cycle; -> HOLD.
//   HOLD  SCL low, SDA unchanged, isReady=1. Accepts start, send, receive, stop.
//   STOP  q0 SDA low, q1 SCL released, q2 SDA released (SCL high), q3 -> IDLE.
//  isReady=0 in START, BITS, ACK and STOP. Commands while isReady=0 are ignored.
//  Simultaneous commands: priority start > stop > send > receive; the rest are dropped.
//  datareceive is updated only together with the received pulse.
//  Latency: send accept -> sended pulse = 36*CLK_DIV + 1 cycles.
//   The same latency applies from receive accept to the received pulse.
//  isReady rises in the same cycle as the sended or received pulse.
// CONFIGURATION
//  I2C_CLOCK_STRETCH_EN defined: in q1/q2, while scl_oe=0 and scl_i=0, the timer
//   freezes, so a slave can stretch SCL. This applies in every state, including START
//   and STOP.
//  Undefined: scl_i is ignored; the timer free-runs (no stretching, fixed bit time).
// STRUCTURE
//  i2c_pkg: FSM state encoding (IDLE..STOP), quarter indices Q0..Q3,
//   ACK/NACK constants.
//  One sub-module: i2c_quarter_timer (CLK_DIV counter, tick, freeze input used by
//   the stretching logic).
//  Top module holds the FSM, bit counter, shift register and output registers.
// TESTING (CLK_DIV=4, slave model on SDA/SCL)
//  1. reset then idle 100 cycles -> scl_oe=sda_oe=0, isReady=1, no pulses.
//  2. start, send 0xA5, slave ACKs -> SDA bits 1,0,1,0,0,1,0,1;
//     sended at +145 cycles; ackError=0.
//  3. send 0x3C, no slave ACK -> ackError=1 with sended; next stop ->
//     SDA rises while SCL high; then IDLE.
//  4. start, receive with nackLast=0, slave drives 0x5A -> datareceive=0x5A
//     with received; ACK slot SDA low. Repeat with nackLast=1 -> SDA released.
//  5. start and send in the same cycle from IDLE -> only START; send pulsed
//     during START is ignored.
//  6. reset asserted in mid BITS -> next cycle lines released, isReady=1, no pulse.
//     With I2C_CLOCK_STRETCH_EN, the slave holds SCL low 20 cycles -> the bit
//     stretches by 20.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bit engine: FSM state encoding,
// quarter-slot indices inside one SCL bit period, and ACK/NACK bus levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BITS  = 3'd2,
        ST_ACK   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    typedef logic [1:0] qtr_t;

    // q0: SCL low / set SDA, q1: SCL release, q2: SCL high / sample, q3: SCL low
    localparam qtr_t Q0 = 2'd0;
    localparam qtr_t Q1 = 2'd1;
    localparam qtr_t Q2 = 2'd2;
    localparam qtr_t Q3 = 2'd3;

    // SDA level seen in the acknowledge slot
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: counts 0..CLK_DIV-1 while running and emits a one-cycle
// tick on the last count. clear restarts it at 0; freeze holds the count so a
// slave can stretch SCL.
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic freeze,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and tick generation
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !freeze) begin
            if (cnt_q == CNT_LAST) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: turns start/send/receive/stop byte commands into
// open-drain SCL/SDA activity at a fixed rate of 4*CLK_DIV clocks per bit.
// Optional feature macro: I2C_CLOCK_STRETCH_EN (timer freezes in q1/q2 while a
// slave holds released SCL low). Without it scl_i is ignored.
module i2c_bit_engine
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    output logic       isReady,
    input  logic       start,
    input  logic       send,
    input  logic [7:0] datasend,
    output logic       sended,
    input  logic       receive,
    input  logic       nackLast,
    output logic [7:0] datareceive,
    output logic       received,
    input  logic       stop,
    output logic       ackError,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic       scl_i
);

    state_t      state_q, state_d;
    qtr_t        qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_q, rx_d;
    logic        nack_q, nack_d;
    logic        ack_err_q, ack_err_d;
    logic        sended_q, sended_d;
    logic        received_q, received_d;
    logic [7:0]  datarx_q, datarx_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;

    logic        cmd_accept;
    logic        timer_run;
    logic        stretch_hold;
    logic        tick;

    assign timer_run = (state_q != ST_IDLE) && (state_q != ST_HOLD);

`ifdef I2C_CLOCK_STRETCH_EN
    // SCL released by us but still low on the pin: a slave is stretching
    assign stretch_hold = ((qtr_q == Q1) || (qtr_q == Q2)) && !scl_oe_q && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stretch_hold = 1'b0;
`endif

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (cmd_accept),
        .run    (timer_run),
        .freeze (stretch_hold),
        .tick   (tick)
    );

    // Command acceptance, state sequencing, bit shifting and result capture
    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        nack_d     = nack_q;
        ack_err_d  = ack_err_q;
        datarx_d   = datarx_q;
        sended_d   = 1'b0;
        received_d = 1'b0;
        cmd_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_START;
                    qtr_d      = Q0;
                    cmd_accept = 1'b1;
                end
            end
            ST_HOLD: begin
                // start > stop > send > receive; lower-priority commands are dropped
                if (start) begin
                    state_d    = ST_START;
                    qtr_d      = Q0;
                    cmd_accept = 1'b1;
                end else if (stop) begin
                    state_d    = ST_STOP;
                    qtr_d      = Q0;
                    cmd_accept = 1'b1;
                end else if (send) begin
                    state_d    = ST_BITS;
                    qtr_d      = Q0;
                    bit_d      = 3'd7;
                    rx_d       = 1'b0;
                    shift_d    = datasend;
                    ack_err_d  = 1'b0;
                    cmd_accept = 1'b1;
                end else if (receive) begin
                    state_d    = ST_BITS;
                    qtr_d      = Q0;
                    bit_d      = 3'd7;
                    rx_d       = 1'b1;
                    nack_d     = nackLast;
                    cmd_accept = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == Q3) state_d = ST_HOLD;
                end
            end
            ST_BITS: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if ((qtr_q == Q2) && rx_q) shift_d = {shift_q[6:0], sda_i};
                    if (qtr_q == Q3) begin
                        if (bit_q == 3'd0) state_d = ST_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if ((qtr_q == Q2) && !rx_q) ack_err_d = (sda_i == NACK_BIT);
                    if (qtr_q == Q3) begin
                        state_d = ST_HOLD;
                        if (rx_q) begin
                            received_d = 1'b1;
                            datarx_d   = shift_q;
                        end else begin
                            sended_d = 1'b1;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == Q3) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Open-drain line decode from the current state and quarter
    always_comb begin
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        case (state_q)
            ST_IDLE: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
            ST_START: begin
                case (qtr_q)
                    Q0:      sda_oe_d = 1'b0;
                    Q1:      begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                    Q2:      begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
                    default: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
                endcase
            end
            ST_BITS: begin
                scl_oe_d = (qtr_q == Q0) || (qtr_q == Q3);
                sda_oe_d = rx_q ? 1'b0 : ~shift_q[bit_q];
            end
            ST_ACK: begin
                scl_oe_d = (qtr_q == Q0) || (qtr_q == Q3);
                sda_oe_d = rx_q ? (nack_q == ACK_BIT) : 1'b0;
            end
            ST_HOLD: begin
                scl_oe_d = 1'b1;
            end
            ST_STOP: begin
                case (qtr_q)
                    Q0:      begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
                    Q1:      begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
                    default: begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                endcase
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            qtr_q      <= Q0;
            bit_q      <= 3'd7;
            shift_q    <= '0;
            rx_q       <= 1'b0;
            nack_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            sended_q   <= 1'b0;
            received_q <= 1'b0;
            datarx_q   <= '0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            nack_q     <= nack_d;
            ack_err_q  <= ack_err_d;
            sended_q   <= sended_d;
            received_q <= received_d;
            datarx_q   <= datarx_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign isReady     = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign sended      = sended_q;
    assign received    = received_q;
    assign datareceive = datarx_q;
    assign ackError    = ack_err_q;
    assign scl_oe      = scl_oe_q;
    assign sda_oe      = sda_oe_q;

endmodule
